// File: rtl/line_checker_if.sv
// Byte-stream handshake between the UART receiver and the line checker.
// The source drives rx_valid/rx_data, and the checker answers with rx_ready.
interface line_checker_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;

    modport master (output rx_valid, output rx_data, input rx_ready);
    modport slave  (input rx_valid, input rx_data, output rx_ready);
endinterface

// File: rtl/line_checker.sv
// Assembles terminator-delimited lines from a byte stream.
// Each line is compared on the fly against a host-programmable expected string, with read/ok/error counters.
module line_checker #(
    parameter int          MAX_LEN = 32,
    parameter int          CNT_W   = 16,
    parameter logic [7:0]  TERM    = 8'h0A,
    parameter logic [7:0]  SKIP    = 8'h0D,
    parameter int          IDX_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             resetb,
    line_checker_if.slave    rx,
    input  logic             exp_we,
    input  logic [IDX_W-1:0] exp_addr,
    input  logic [7:0]       exp_data,
    input  logic [IDX_W-1:0] exp_len,
    input  logic             clr_cnt,
    output logic             result_valid,
    output logic             result_ok,
    output logic [IDX_W-1:0] result_len,
    output logic [CNT_W-1:0] cnt_rd,
    output logic [CNT_W-1:0] cnt_ok,
    output logic [CNT_W-1:0] cnt_error
);

    // The buffer is padded to a power of two so idx slices index it cleanly.
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(MAX_LEN);

    typedef enum logic [1:0] {RECV, DRAIN, REPORT} state_t;

    state_t           state;
    state_t           next_state;
    logic [IDX_W-1:0] idx;
    logic             mismatch;
    logic             final_ok;
    logic [IDX_W-1:0] len_q;
    logic [7:0]       exp_mem [0:(1<<AW)-1];
    logic             accept;
    logic             is_term;
    logic             is_skip;

    assign rx.rx_ready  = resetb && (state != REPORT);
    assign accept       = rx.rx_valid && rx.rx_ready;
    assign is_term      = (rx.rx_data == TERM);
    assign is_skip      = (rx.rx_data == SKIP);
    assign result_valid = (state == REPORT);
    assign result_ok    = (state == REPORT) && final_ok;
    assign result_len   = len_q;

    // The expected buffer is left untouched by reset, so it survives resets.
    always_ff @(posedge clk) begin
        if (exp_we && (exp_addr < MAX_IDX)) begin
            exp_mem[exp_addr[AW-1:0]] <= exp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            state <= RECV;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            RECV: begin
                if (accept && is_term) begin
                    next_state = REPORT;
                end else if (accept && !is_skip && (idx == MAX_IDX)) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (accept && is_term) begin
                    next_state = REPORT;
                end
            end
            REPORT:  next_state = RECV;
            default: next_state = RECV;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            idx      <= '0;
            mismatch <= 1'b0;
            final_ok <= 1'b0;
            len_q    <= '0;
        end else begin
            case (state)
                RECV: begin
                    if (accept && is_term) begin
                        final_ok <= !mismatch && (idx == exp_len);
                        len_q    <= idx;
                    end else if (accept && !is_skip) begin
                        if (idx < MAX_IDX) begin
                            if ((idx >= exp_len) || (rx.rx_data != exp_mem[idx[AW-1:0]])) begin
                                mismatch <= 1'b1;
                            end
                            idx <= idx + 1'b1;
                        end else begin
                            mismatch <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (accept && is_term) begin
                        final_ok <= 1'b0;
                        len_q    <= idx;
                    end
                end
                REPORT: begin
                    idx      <= '0;
                    mismatch <= 1'b0;
                end
                default: begin
                    idx      <= '0;
                    mismatch <= 1'b0;
                end
            endcase
        end
    end

    // A clear coinciding with a report restarts the affected counters at one.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            cnt_rd    <= '0;
            cnt_ok    <= '0;
            cnt_error <= '0;
        end else begin
            if (state == REPORT) begin
                cnt_rd <= clr_cnt ? CNT_W'(1) : ((cnt_rd == '1) ? cnt_rd : cnt_rd + CNT_W'(1));
            end else if (clr_cnt) begin
                cnt_rd <= '0;
            end
            if ((state == REPORT) && final_ok) begin
                cnt_ok <= clr_cnt ? CNT_W'(1) : ((cnt_ok == '1) ? cnt_ok : cnt_ok + CNT_W'(1));
            end else if (clr_cnt) begin
                cnt_ok <= '0;
            end
            if ((state == REPORT) && !final_ok) begin
                cnt_error <= clr_cnt ? CNT_W'(1) : ((cnt_error == '1) ? cnt_error : cnt_error + CNT_W'(1));
            end else if (clr_cnt) begin
                cnt_error <= '0;
            end
        end
    end

endmodule

// File: tb/tb_line_checker.sv
// Directed bench for line_checker: MAX_LEN=32, CNT_W=4 so saturation is reachable quickly.
module tb_line_checker;
    localparam int IDX_W = 6;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             resetb = 1'b0;
    logic             exp_we = 1'b0;
    logic [IDX_W-1:0] exp_addr = '0;
    logic [7:0]       exp_data = '0;
    logic [IDX_W-1:0] exp_len = '0;
    logic             clr_cnt = 1'b0;
    logic             result_valid;
    logic             result_ok;
    logic [IDX_W-1:0] result_len;
    logic [CNT_W-1:0] cnt_rd;
    logic [CNT_W-1:0] cnt_ok;
    logic [CNT_W-1:0] cnt_error;

    line_checker_if bus ();

    line_checker #(.MAX_LEN(32), .CNT_W(CNT_W)) dut (
        .clk(clk), .resetb(resetb), .rx(bus.slave),
        .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data), .exp_len(exp_len),
        .clr_cnt(clr_cnt), .result_valid(result_valid), .result_ok(result_ok),
        .result_len(result_len), .cnt_rd(cnt_rd), .cnt_ok(cnt_ok), .cnt_error(cnt_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int pulses = 0;
    int ready_errs = 0;
    logic last_ok = 1'b0;
    logic [IDX_W-1:0] last_len = '0;

    // Records every result pulse and flags rx_ready disagreeing with the REPORT cycle.
    always @(negedge clk) begin
        if (result_valid === 1'b1) begin
            pulses++;
            last_ok = result_ok;
            last_len = result_len;
        end
        if (resetb === 1'b1 && bus.rx_ready !== ~result_valid) ready_errs++;
    end

    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        bus.rx_valid = 1'b1;
        bus.rx_data = b;
        while (bus.rx_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) begin
            failures++;
            $display("[TB] FAIL send_timeout: rx_ready=%b required 1", bus.rx_ready);
        end
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic finish_line();
        send_byte(8'h0A);
        @(posedge clk);
        #1;
    endtask

    task automatic load_exp(input string s);
        for (int i = 0; i < s.len(); i++) begin
            exp_we = 1'b1;
            exp_addr = IDX_W'(i);
            exp_data = s[i];
            @(posedge clk);
            #1;
        end
        exp_we = 1'b0;
        exp_len = IDX_W'(s.len());
    endtask

    task automatic pulse_clr();
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
    endtask

    task automatic test_reset();
        bus.rx_valid = 1'b0;
        bus.rx_data = 8'h00;
        resetb = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.rx_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready: got %b expected 0", bus.rx_ready); end
        checks++;
        if ({result_valid, result_ok, result_len} !== '0) begin failures++; $display("[TB] FAIL reset_result: got %b/%b/%0d expected 0/0/0", result_valid, result_ok, result_len); end
        checks++;
        if ({cnt_rd, cnt_ok, cnt_error} !== '0) begin failures++; $display("[TB] FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0", cnt_rd, cnt_ok, cnt_error); end
        resetb = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_hello();
        int p0;
        load_exp("Hello, world! 123 ");
        p0 = pulses;
        send_str("Hello, world! 123 ");
        send_byte(8'h0D);
        finish_line();
        checks++;
        if (pulses - p0 !== 1) begin failures++; $display("[TB] FAIL hello_pulses: got %0d expected 1", pulses - p0); end
        checks++;
        if (last_ok !== 1'b1 || last_len !== 6'd18) begin failures++; $display("[TB] FAIL hello_result: got ok=%b len=%0d expected ok=1 len=18", last_ok, last_len); end
        checks++;
        if (cnt_rd !== 4'd1 || cnt_ok !== 4'd1 || cnt_error !== 4'd0) begin failures++; $display("[TB] FAIL hello_counters: got %0d/%0d/%0d expected 1/1/0", cnt_rd, cnt_ok, cnt_error); end
        checks++;
        if (result_ok !== 1'b0 || result_len !== 6'd18) begin failures++; $display("[TB] FAIL hello_hold: got ok=%b len=%0d expected ok=0 len=18", result_ok, result_len); end
    endtask

    task automatic test_match();
        pulse_clr();
        load_exp("0123456789");
        send_str("0123456789");
        finish_line();
        checks++;
        if (last_ok !== 1'b1 || last_len !== 6'd10) begin failures++; $display("[TB] FAIL match_ok: got ok=%b len=%0d expected ok=1 len=10", last_ok, last_len); end
        send_str("0123X56789");
        finish_line();
        checks++;
        if (last_ok !== 1'b0 || last_len !== 6'd10) begin failures++; $display("[TB] FAIL match_bad: got ok=%b len=%0d expected ok=0 len=10", last_ok, last_len); end
        checks++;
        if (cnt_rd !== 4'd2 || cnt_ok !== 4'd1 || cnt_error !== 4'd1) begin failures++; $display("[TB] FAIL match_counters: got %0d/%0d/%0d expected 2/1/1", cnt_rd, cnt_ok, cnt_error); end
    endtask

    task automatic test_length();
        send_str("012345678");
        finish_line();
        checks++;
        if (last_ok !== 1'b0 || last_len !== 6'd9) begin failures++; $display("[TB] FAIL short_line: got ok=%b len=%0d expected ok=0 len=9", last_ok, last_len); end
        send_str("01234567890");
        finish_line();
        checks++;
        if (last_ok !== 1'b0 || last_len !== 6'd11) begin failures++; $display("[TB] FAIL long_line: got ok=%b len=%0d expected ok=0 len=11", last_ok, last_len); end
        send_str("\r01\r2345678\r");
        finish_line();
        checks++;
        if (last_ok !== 1'b0 || last_len !== 6'd9) begin failures++; $display("[TB] FAIL short_skip: got ok=%b len=%0d expected ok=0 len=9", last_ok, last_len); end
        send_str("0123\r456789\r");
        finish_line();
        checks++;
        if (last_ok !== 1'b1 || last_len !== 6'd10) begin failures++; $display("[TB] FAIL match_skip: got ok=%b len=%0d expected ok=1 len=10", last_ok, last_len); end
    endtask

    task automatic test_overflow();
        int drops = 0;
        pulse_clr();
        for (int i = 0; i < 40; i++) begin
            if (bus.rx_ready !== 1'b1) drops++;
            send_byte(8'h41);
        end
        checks++;
        if (drops !== 0) begin failures++; $display("[TB] FAIL drain_ready: got %0d low cycles expected 0", drops); end
        finish_line();
        checks++;
        if (last_ok !== 1'b0 || last_len !== 6'd32) begin failures++; $display("[TB] FAIL overflow: got ok=%b len=%0d expected ok=0 len=32", last_ok, last_len); end
        checks++;
        if (cnt_rd !== 4'd1 || cnt_ok !== 4'd0 || cnt_error !== 4'd1) begin failures++; $display("[TB] FAIL overflow_counters: got %0d/%0d/%0d expected 1/0/1", cnt_rd, cnt_ok, cnt_error); end
        exp_len = '0;
        finish_line();
        checks++;
        if (last_ok !== 1'b1 || last_len !== 6'd0) begin failures++; $display("[TB] FAIL empty_line: got ok=%b len=%0d expected ok=1 len=0", last_ok, last_len); end
        exp_len = 6'd10;
    endtask

    task automatic test_back_to_back();
        string s = "0123456789";
        int p0 = pulses;
        for (int l = 0; l < 3; l++) begin
            for (int i = 0; i < s.len(); i++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                send_byte(s[i]);
            end
            send_byte(8'h0A);
        end
        send_str("01234567");
        finish_line();
        checks++;
        if (pulses - p0 !== 4) begin failures++; $display("[TB] FAIL b2b_pulses: got %0d expected 4", pulses - p0); end
        checks++;
        if (last_ok !== 1'b0 || last_len !== 6'd8) begin failures++; $display("[TB] FAIL b2b_last: got ok=%b len=%0d expected ok=0 len=8", last_ok, last_len); end
        checks++;
        if (ready_errs !== 0) begin failures++; $display("[TB] FAIL ready_report: got %0d bad cycles expected 0", ready_errs); end
    endtask

    task automatic test_reset_midline();
        int p0;
        send_str("01234");
        p0 = pulses;
        resetb = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (pulses !== p0 || {cnt_rd, cnt_ok, cnt_error} !== '0) begin failures++; $display("[TB] FAIL midline_reset: got pulses=%0d cnt=%0d/%0d/%0d expected pulses=%0d cnt=0/0/0", pulses, cnt_rd, cnt_ok, cnt_error, p0); end
        resetb = 1'b1;
        @(posedge clk);
        #1;
        send_str("0123456789");
        finish_line();
        checks++;
        if (last_ok !== 1'b1 || cnt_rd !== 4'd1 || cnt_ok !== 4'd1) begin failures++; $display("[TB] FAIL after_reset: got ok=%b rd=%0d okc=%0d expected 1/1/1", last_ok, cnt_rd, cnt_ok); end
    endtask

    task automatic test_saturation();
        pulse_clr();
        for (int l = 0; l < 20; l++) begin
            send_str("0123456789");
            finish_line();
        end
        checks++;
        if (cnt_rd !== 4'd15 || cnt_ok !== 4'd15 || cnt_error !== 4'd0) begin failures++; $display("[TB] FAIL saturate: got %0d/%0d/%0d expected 15/15/0", cnt_rd, cnt_ok, cnt_error); end
        send_str("9999");
        send_byte(8'h0A);
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        checks++;
        if (cnt_rd !== 4'd1 || cnt_ok !== 4'd0 || cnt_error !== 4'd1 || last_ok !== 1'b0) begin failures++; $display("[TB] FAIL clr_on_report: got %0d/%0d/%0d ok=%b expected 1/0/1 ok=0", cnt_rd, cnt_ok, cnt_error, last_ok); end
    endtask

    task automatic test_write_collision();
        send_str("012");
        exp_we = 1'b1;
        exp_addr = 6'd3;
        exp_data = 8'h5A;
        send_byte(8'h33);
        exp_we = 1'b0;
        send_str("456789");
        finish_line();
        checks++;
        if (last_ok !== 1'b1) begin failures++; $display("[TB] FAIL old_contents: got ok=%b expected 1", last_ok); end
        send_str("0123456789");
        finish_line();
        checks++;
        if (last_ok !== 1'b0) begin failures++; $display("[TB] FAIL new_contents: got ok=%b expected 0", last_ok); end
        exp_we = 1'b1;
        exp_addr = 6'd40;
        exp_data = 8'h33;
        @(posedge clk);
        #1;
        exp_we = 1'b0;
        send_str("012Z456789");
        finish_line();
        checks++;
        if (last_ok !== 1'b1) begin failures++; $display("[TB] FAIL ignored_write: got ok=%b expected 1", last_ok); end
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data = 8'h00;
        test_reset();
        test_hello();
        test_match();
        test_length();
        test_overflow();
        test_back_to_back();
        test_reset_midline();
        test_saturation();
        test_write_collision();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
